// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the multicycle RV32I control path: FSM states,
// opcodes, ALUOp / alu_control codes and datapath mux select codes.
package multicycle_controller_pkg;

    // FSM state encoding, visible externally on state_dbg
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_ALUWB    = 4'd7,
        S_EXECUTEI = 4'd8,
        S_JAL      = 4'd9,
        S_BEQ      = 4'd10,
        S_TRAP     = 4'd11
    } state_t;

    // Supported opcodes
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    // ALUOp: what the controller asks of the ALU decoder
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // alu_control: operation seen by the ALU
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    // Result mux select
    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    // ALU A / B operand selects
    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;
    localparam logic [1:0] SRCB_RS2   = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;

    // Immediate format select
    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    // State entered after DECODE for a given opcode
    function automatic state_t decode_target(input logic [6:0] op);
        case (op)
            OP_LW, OP_SW: return S_MEMADR;
            OP_R:         return S_EXECUTER;
            OP_I:         return S_EXECUTEI;
            OP_JAL:       return S_JAL;
            OP_BEQ:       return S_BEQ;
            default:      return S_TRAP;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_controller_alu_dec.sv
// ALU control decoder: maps ALUOp plus instruction fields to the ALU
// operation code.
module multicycle_controller_alu_dec
    import multicycle_controller_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [2:0] funct3,
    input  logic       op5,
    input  logic       funct7b5,
    output logic [2:0] alu_control
);

    // Decode the ALU operation; sub only for R-type with funct7 bit 5 set
    always_comb begin
        // NOTE: a default before the case keeps every path assigned, so no latch is inferred.
        alu_control = ALU_ADD;
        case (alu_op)
            ALUOP_ADD: alu_control = ALU_ADD;
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    3'b000:  alu_control = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control = ALU_SLT;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Main control FSM of the multicycle RV32I subset core (lw, sw, R-type,
// I-type ALU, jal, beq). Sequences the shared datapath, stalls on
// mem_ready, traps on illegal opcodes and counts retired instructions.
module multicycle_controller
    import multicycle_controller_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       op,
    input  logic [2:0]       funct3,
    input  logic             funct7b5,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             adr_src,
    output logic             mem_write,
    output logic             ir_write,
    output logic [1:0]       result_src,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       imm_src,
    output logic             reg_write,
    output logic [2:0]       alu_control,
    output logic             illegal,
    output logic [CNT_W-1:0] retired,
    output logic [3:0]       state_dbg
);

    state_t     state;
    logic [1:0] alu_op;

    assign state_dbg = state;

    // State register, sticky illegal flag and retired-instruction counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_FETCH;
            illegal <= 1'b0;
            retired <= '0;
        end else begin
            // NOTE: state is updated with <= so every flop samples pre-edge values.
            case (state)
                S_FETCH: begin
                    if (mem_ready) state <= S_DECODE;
                end
                S_DECODE: begin
                    state <= decode_target(op);
                    if (decode_target(op) == S_TRAP) illegal <= 1'b1;
                end
                S_MEMADR: begin
                    state <= (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
                end
                S_MEMREAD: begin
                    if (mem_ready) state <= S_MEMWB;
                end
                S_MEMWRITE: begin
                    if (mem_ready) begin
                        state   <= S_FETCH;
                        retired <= retired + CNT_W'(1);
                    end
                end
                S_EXECUTER, S_EXECUTEI, S_JAL: begin
                    state <= S_ALUWB;
                end
                S_MEMWB, S_ALUWB, S_BEQ: begin
                    state   <= S_FETCH;
                    retired <= retired + CNT_W'(1);
                end
                S_TRAP: begin
                    state <= S_TRAP;
                end
                default: begin
                    state <= S_TRAP;
                end
            endcase
        end
    end

    // Moore datapath controls; only FETCH looks at mem_ready, and the
    // write enables are held off while reset is asserted
    always_comb begin
        pc_write   = 1'b0;
        adr_src    = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        result_src = RES_ALUOUT;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_RS2;
        alu_op     = ALUOP_ADD;
        case (state)
            S_FETCH: begin
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALURESULT;
                ir_write   = mem_ready;
                pc_write   = mem_ready;
            end
            S_DECODE: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
            end
            S_MEMADR: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
            end
            S_MEMREAD: begin
                adr_src = 1'b1;
            end
            S_MEMWB: begin
                result_src = RES_DATA;
                reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                adr_src   = 1'b1;
                mem_write = 1'b1;
            end
            S_EXECUTER: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_RS2;
                alu_op    = ALUOP_FUNCT;
            end
            S_EXECUTEI: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
            end
            S_JAL: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_FOUR;
                pc_write  = 1'b1;
            end
            S_BEQ: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_RS2;
                alu_op    = ALUOP_SUB;
                pc_write  = zero;
            end
            default: begin
            end
        endcase
        if (!rst_n) begin
            pc_write  = 1'b0;
            mem_write = 1'b0;
            ir_write  = 1'b0;
            reg_write = 1'b0;
        end
    end

    // Immediate format follows the opcode directly
    always_comb begin
        case (op)
            OP_LW, OP_I: imm_src = IMM_I;
            OP_SW:       imm_src = IMM_S;
            OP_BEQ:      imm_src = IMM_B;
            OP_JAL:      imm_src = IMM_J;
            default:     imm_src = IMM_I;
        endcase
    end

    multicycle_controller_alu_dec u_alu_dec (
        .alu_op      (alu_op),
        .funct3      (funct3),
        .op5         (op[5]),
        .funct7b5    (funct7b5),
        .alu_control (alu_control)
    );

endmodule
